byte_assembler_8: RTL and testbench

Serial-to-parallel byte assembler that feeds one bit per accepted transfer into an 8-slot collection register and presents completed bytes on a valid/ready output. It uses the 1-to-8 demultiplexer as its slot write-enable decoder and drives the select from an internal 3-bit slot counter. It sits between a bit-serial source (valid/ready) and any byte-wide consumer. A double-buffered output stage lets collection of byte N+1 proceed while byte N waits to be drained.

---
 rtl/byte_asm_pkg.sv | 18 +
 rtl/demux_1to8.sv | 13 +
 rtl/byte_assembler_8.sv | 94 +++++++++
 tb/tb_byte_assembler_8.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_asm_pkg.sv
// Shared widths, output-stage state encoding and slot mapping for the byte assembler.
package byte_asm_pkg;

  localparam int unsigned SLOT_W    = 3;
  localparam int unsigned NUM_SLOTS = 8;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Counter slot to physical bit position of the collection register.
  function automatic logic [SLOT_W-1:0] map_slot(input logic [SLOT_W-1:0] slot,
                                                 input logic              msb_first);
    return msb_first ? (SLOT_W'(NUM_SLOTS - 1) - slot) : slot;
  endfunction

endpackage

// File: rtl/demux_1to8.sv
// 1-to-8 demultiplexer: routes input a to output f[sel], all other outputs low.
module demux_1to8 (
  input  logic       a,
  input  logic [2:0] sel,
  output logic [7:0] f
);

  always_comb begin
    f      = '0;
    f[sel] = a;
  end

endmodule

// File: rtl/byte_assembler_8.sv
// Bit-serial to byte assembler with a double-buffered valid/ready output stage.
module byte_assembler_8
  import byte_asm_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [SLOT_W-1:0] slot
);

  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [SLOT_W-1:0]    sel;
  logic [NUM_SLOTS-1:0] slot_we;
  logic [7:0]           coll_q, coll_d;
  logic [7:0]           out_q, out_d;
  out_state_t           state_q, state_d;
  logic                 last_slot;
  logic                 accept;
  logic                 complete;
  logic                 drain;

  assign byte_valid = (state_q == OUT_FULL);
  assign last_slot  = (slot_q == SLOT_W'(NUM_SLOTS - 1));
  // Only the completing bit waits on a full, undrained output register.
  assign bit_ready  = !(last_slot && byte_valid && !byte_ready);
  assign accept     = bit_valid && bit_ready;
  assign complete   = accept && last_slot;
  assign drain      = byte_valid && byte_ready;
  assign sel        = map_slot(slot_q, MSB_FIRST);

  demux_1to8 u_slot_dec (
    .a   (accept),
    .sel (sel),
    .f   (slot_we)
  );

  always_comb begin
    coll_d = coll_q;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (slot_we[i]) begin
        coll_d[i] = bit_in;
      end
    end
  end

  assign slot_d = accept ? (slot_q + SLOT_W'(1)) : slot_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    unique case (state_q)
      OUT_EMPTY: begin
        if (complete) begin
          state_d = OUT_FULL;
          out_d   = coll_d;
        end
      end
      OUT_FULL: begin
        // A completion here implies a same-cycle drain, so the new byte replaces the old.
        if (complete) begin
          out_d = coll_d;
        end else if (drain) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '0;
      coll_q  <= '0;
      out_q   <= '0;
      state_q <= OUT_EMPTY;
    end else begin
      slot_q  <= slot_d;
      coll_q  <= coll_d;
      out_q   <= out_d;
      state_q <= state_d;
    end
  end

  assign byte_out = out_q;
  assign slot     = slot_q;

endmodule

// File: tb/tb_byte_assembler_8.sv
// Directed bench: an LSB-first and an MSB-first instance share one bit stream.
module tb_byte_assembler_8;

  logic       clk;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       byte_ready;
  logic       bit_ready0, bit_ready1;
  logic [7:0] byte_out0, byte_out1;
  logic       byte_valid0, byte_valid1;
  logic [2:0] slot0, slot1;

  int checks;
  int failures;
  int deliveries;
  logic [7:0] last0, last1;

  byte_assembler_8 #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready0),
    .byte_out   (byte_out0),
    .byte_valid (byte_valid0),
    .byte_ready (byte_ready),
    .slot       (slot0)
  );

  byte_assembler_8 #(.MSB_FIRST(1'b1)) dut_msb (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready1),
    .byte_out   (byte_out1),
    .byte_valid (byte_valid1),
    .byte_ready (byte_ready),
    .slot       (slot1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change at posedge+1, so a handshake seen at negedge completes at the next edge.
  initial deliveries = 0;
  always @(negedge clk) begin
    if (!rst && byte_valid0 && byte_ready) begin
      deliveries = deliveries + 1;
      last0      = byte_out0;
      last1      = byte_out1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present seq[0] first; each bit waits (bounded) for bit_ready.
  task automatic send_seq(input logic [7:0] seq);
    for (int i = 0; i < 8; i++) begin
      int n;
      bit_valid = 1'b1;
      bit_in    = seq[i];
      n = 0;
      @(negedge clk);
      while (!bit_ready0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) begin
        checks++;
        failures++;
        $display("FAIL send_seq timeout: bit_ready=%b required 1", bit_ready0);
      end
      tick();
    end
    bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; byte_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        rst = 1'b0; bit_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (byte_valid0 !== 1'b0 || byte_valid1 !== 1'b0) begin
        failures++;
        $display("FAIL reset byte_valid c%0d: got %b/%b required 0/0", c, byte_valid0, byte_valid1);
      end
      checks++;
      if (byte_out0 !== 8'h00 || byte_out1 !== 8'h00) begin
        failures++;
        $display("FAIL reset byte_out c%0d: got %h/%h required 00/00", c, byte_out0, byte_out1);
      end
      checks++;
      if (slot0 !== 3'd0 || slot1 !== 3'd0) begin
        failures++;
        $display("FAIL reset slot c%0d: got %0d/%0d required 0/0", c, slot0, slot1);
      end
      checks++;
      if (bit_ready0 !== 1'b1) begin
        failures++;
        $display("FAIL reset bit_ready c%0d: got %b required 1", c, bit_ready0);
      end
    end
    tick();
  endtask

  task automatic test_byte(input string name, input logic [7:0] seq,
                           input logic [7:0] exp0, input logic [7:0] exp1);
    byte_ready = 1'b1;
    send_seq(seq);
    @(negedge clk);
    checks++;
    if (byte_valid0 !== 1'b1 || byte_out0 !== exp0) begin
      failures++;
      $display("FAIL %s lsb: got valid=%b out=%h required valid=1 out=%h",
               name, byte_valid0, byte_out0, exp0);
    end
    checks++;
    if (byte_valid1 !== 1'b1 || byte_out1 !== exp1) begin
      failures++;
      $display("FAIL %s msb: got valid=%b out=%h required valid=1 out=%h",
               name, byte_valid1, byte_out1, exp1);
    end
    checks++;
    if (slot0 !== 3'd0) begin
      failures++;
      $display("FAIL %s slot wrap: got %0d required 0", name, slot0);
    end
    tick();
    @(negedge clk);
    checks++;
    if (byte_valid0 !== 1'b0) begin
      failures++;
      $display("FAIL %s pulse: byte_valid got %b required 0", name, byte_valid0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    stream     = 16'h6996;
    byte_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      bit_valid = 1'b1;
      bit_in    = stream[c];
      @(negedge clk);
      checks++;
      if (bit_ready0 !== 1'b1) begin
        failures++;
        $display("FAIL b2b bubble c%0d: bit_ready got %b required 1", c, bit_ready0);
      end
      if (c == 8) begin
        checks++;
        if (byte_valid0 !== 1'b1 || byte_out0 !== 8'h96 || byte_out1 !== 8'h69) begin
          failures++;
          $display("FAIL b2b first byte: got v=%b %h/%h required v=1 96/69",
                   byte_valid0, byte_out0, byte_out1);
        end
      end
      tick();
    end
    bit_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (byte_valid0 !== 1'b1 || byte_out0 !== 8'h69 || byte_out1 !== 8'h96) begin
      failures++;
      $display("FAIL b2b second byte: got v=%b %h/%h required v=1 69/96",
               byte_valid0, byte_out0, byte_out1);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] seq;
    byte_ready = 1'b0;
    send_seq(8'h3C);
    seq = 8'h5A;
    for (int i = 0; i < 7; i++) begin
      bit_valid = 1'b1;
      bit_in    = seq[i];
      @(negedge clk);
      checks++;
      if (bit_ready0 !== 1'b1 || byte_out0 !== 8'h3C || byte_valid0 !== 1'b1) begin
        failures++;
        $display("FAIL bp accept bit%0d: got ready=%b v=%b out=%h required 1 1 3c",
                 i, bit_ready0, byte_valid0, byte_out0);
      end
      tick();
    end
    bit_in = seq[7];
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bit_ready0 !== 1'b0 || slot0 !== 3'd7 || byte_out0 !== 8'h3C || byte_out1 !== 8'h3C) begin
        failures++;
        $display("FAIL bp stall c%0d: got ready=%b slot=%0d out=%h/%h required 0 7 3c/3c",
                 c, bit_ready0, slot0, byte_out0, byte_out1);
      end
      tick();
    end
    byte_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bit_ready0 !== 1'b1) begin
      failures++;
      $display("FAIL bp release: bit_ready got %b required 1", bit_ready0);
    end
    tick();
    bit_valid  = 1'b0;
    byte_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (byte_valid0 !== 1'b1 || byte_out0 !== 8'h5A || byte_out1 !== 8'h5A || slot0 !== 3'd0) begin
      failures++;
      $display("FAIL bp new byte: got v=%b out=%h/%h slot=%0d required 1 5a/5a 0",
               byte_valid0, byte_out0, byte_out1, slot0);
    end
    byte_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_gapped();
    logic [7:0] seq;
    int base;
    seq  = 8'h81;
    base = deliveries;
    byte_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < (i % 3) + 1; g++) begin
        bit_valid = 1'b0;
        bit_in    = ~seq[i];
        @(negedge clk);
        checks++;
        if (slot0 !== 3'(i)) begin
          failures++;
          $display("FAIL gap slot bit%0d: got %0d required %0d", i, slot0, i);
        end
        tick();
      end
      bit_valid = 1'b1;
      bit_in    = seq[i];
      tick();
    end
    bit_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (deliveries - base !== 1 || last0 !== 8'h81 || last1 !== 8'h81) begin
      failures++;
      $display("FAIL gapped delivery: got n=%0d %h/%h required n=1 81/81",
               deliveries - base, last0, last1);
    end
  endtask

  task automatic test_reset_mid_byte();
    int base;
    byte_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (slot0 !== 3'd5) begin
      failures++;
      $display("FAIL mid partial slot: got %0d required 5", slot0);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (slot0 !== 3'd0 || byte_valid0 !== 1'b0 || byte_out0 !== 8'h00) begin
      failures++;
      $display("FAIL mid reset: got slot=%0d v=%b out=%h required 0 0 00",
               slot0, byte_valid0, byte_out0);
    end
    base = deliveries;
    send_seq(8'hFF);
    repeat (4) tick();
    checks++;
    if (deliveries - base !== 1 || last0 !== 8'hFF || last1 !== 8'hFF) begin
      failures++;
      $display("FAIL mid delivery: got n=%0d %h/%h required n=1 ff/ff",
               deliveries - base, last0, last1);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    byte_ready = 1'b0;
    test_reset();
    test_byte("a5", 8'hA5, 8'hA5, 8'hA5);
    test_byte("c0", 8'h03, 8'h03, 8'hC0);
    test_back_to_back();
    test_backpressure();
    test_gapped();
    test_reset_mid_byte();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: sim time exceeded limit");
    $fatal(1);
  end

endmodule
